// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the fabric configuration loader.
// The frame checksum helper is only used when CFG_CHECKSUM_EN is defined.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_ARM    = 3'd5,
    ST_DONE   = 3'd6
  } cfg_state_t;

  localparam int SUM_W       = 16;
  localparam int MAX_FRAME_W = 4096;

  // Frames are zero-extended to MAX_FRAME_W, so unused upper slices fold as zero.
  function automatic logic [SUM_W-1:0] fold_frame(input logic [MAX_FRAME_W-1:0] d);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_FRAME_W / SUM_W; i++) begin
      acc = acc ^ d[i*SUM_W +: SUM_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/cfg_delay_counter.sv
// Loadable down-counter; o_done is high for the single cycle in which the
// loaded count has run out. A load of N-1 yields done in the N-th cycle.
module cfg_delay_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_done = r_run && (r_cnt == '0);

endmodule

// File: rtl/fpga_config_loader.sv
// Streams configuration frames into the fabric, then settles, enables the
// fabric flip-flops and reports ready. Optional checksum: CFG_CHECKSUM_EN.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int FRAME_W       = 320,
  parameter int NUM_FRAMES    = 172,
  parameter int PRE_CYCLES    = 10,
  parameter int SETTLE_CYCLES = 10,
  parameter int ARM_CYCLES    = 1
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          start,
  input  logic [FRAME_W-1:0]            cfg_data,
  input  logic                          cfg_valid,
  input  logic                          cfg_last,
  output logic                          cfg_ready,
  input  logic [SUM_W-1:0]              cfg_sum_exp,
  output logic [FRAME_W-1:0]            configs_in,
  output logic [NUM_FRAMES-1:0]         configs_en,
  output logic                          ff_en,
  output logic                          rdy,
  output logic                          busy,
  output logic                          error,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic [SUM_W-1:0]              cfg_sum
);

  localparam int FI_W    = $clog2(NUM_FRAMES);
  localparam int MAX_A   = (PRE_CYCLES > SETTLE_CYCLES) ? PRE_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > ARM_CYCLES) ? MAX_A : ARM_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  cfg_state_t          r_state;
  logic                r_cfg_ready;
  logic [FRAME_W-1:0]  r_configs_in;
  logic [NUM_FRAMES-1:0] r_configs_en;
  logic                r_ff_en;
  logic                r_rdy;
  logic                r_busy;
  logic                r_error;
  logic [FI_W-1:0]     r_frame_idx;
  logic [SUM_W-1:0]    r_cfg_sum;
  logic                r_final;
  logic                r_bad_len;

  logic                w_accept;
  logic                w_idx_last;
  logic [SUM_W-1:0]    w_sum_next;
  logic                w_sum_bad;
  logic                w_cnt_load;
  logic [CNT_W-1:0]    w_cnt_val;
  logic                w_cnt_done;

  assign w_accept   = (r_state == ST_LOAD) && cfg_valid && r_cfg_ready;
  assign w_idx_last = (r_frame_idx == FI_W'(NUM_FRAMES - 1));

`ifdef CFG_CHECKSUM_EN
  logic [MAX_FRAME_W-1:0] w_data_ext;
  assign w_data_ext = MAX_FRAME_W'(cfg_data);
  assign w_sum_next = r_cfg_sum ^ fold_frame(w_data_ext);
  assign w_sum_bad  = (r_cfg_sum != cfg_sum_exp);
`else
  logic w_unused_sum_exp;
  assign w_unused_sum_exp = ^cfg_sum_exp;
  assign w_sum_next = '0;
  assign w_sum_bad  = 1'b0;
`endif

  // The shared delay counter is loaded on the same edge that enters its state.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(PRE_CYCLES - 1);
        end
      end
      ST_WRITE: begin
        if (r_final && !w_sum_bad) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (w_cnt_done) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(ARM_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  cfg_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clock      (clock),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_done     (w_cnt_done)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cfg_ready  <= 1'b0;
      r_configs_in <= '0;
      r_configs_en <= '0;
      r_ff_en      <= 1'b0;
      r_rdy        <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_frame_idx  <= '0;
      r_cfg_sum    <= '0;
      r_final      <= 1'b0;
      r_bad_len    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_PRE;
            r_error     <= 1'b0;
            r_frame_idx <= '0;
            r_cfg_sum   <= '0;
            r_ff_en     <= 1'b0;
            r_rdy       <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_PRE: begin
          if (w_cnt_done) begin
            r_state     <= ST_LOAD;
            r_cfg_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_state      <= ST_WRITE;
            r_cfg_ready  <= 1'b0;
            r_configs_in <= cfg_data;
            r_configs_en <= NUM_FRAMES'(1) << r_frame_idx;
            r_cfg_sum    <= w_sum_next;
            r_final      <= cfg_last && w_idx_last;
            r_bad_len    <= (cfg_last != w_idx_last);
          end
        end
        ST_WRITE: begin
          r_configs_en <= '0;
          r_frame_idx  <= w_idx_last ? '0 : r_frame_idx + 1'b1;
          if (r_bad_len || (r_final && w_sum_bad)) begin
            r_state <= ST_IDLE;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_final) begin
            r_state <= ST_SETTLE;
          end else begin
            r_state     <= ST_LOAD;
            r_cfg_ready <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (w_cnt_done) begin
            r_state <= ST_ARM;
            r_ff_en <= 1'b1;
          end
        end
        ST_ARM: begin
          if (w_cnt_done) begin
            r_state <= ST_DONE;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign configs_in = r_configs_in;
  assign configs_en = r_configs_en;
  assign ff_en      = r_ff_en;
  assign rdy        = r_rdy;
  assign busy       = r_busy;
  assign error      = r_error;
  assign frame_idx  = r_frame_idx;
  assign cfg_sum    = r_cfg_sum;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomized bench for fpga_config_loader with a stream-level reference model.
module tb_fpga_config_loader;

  localparam int FW     = 32;
  localparam int NF     = 4;
  localparam int PRE    = 2;
  localparam int SETTLE = 3;
  localparam int ARM    = 1;
`ifdef CFG_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_last = 1'b0;
  logic          cfg_ready;
  logic [15:0]   cfg_sum_exp = '0;
  logic [FW-1:0] configs_in;
  logic [NF-1:0] configs_en;
  logic          ff_en, rdy, busy, error;
  logic [1:0]    frame_idx;
  logic [15:0]   cfg_sum;

  fpga_config_loader #(
    .FRAME_W(FW), .NUM_FRAMES(NF), .PRE_CYCLES(PRE),
    .SETTLE_CYCLES(SETTLE), .ARM_CYCLES(ARM)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
    .cfg_sum_exp(cfg_sum_exp), .configs_in(configs_in), .configs_en(configs_en),
    .ff_en(ff_en), .rdy(rdy), .busy(busy), .error(error),
    .frame_idx(frame_idx), .cfg_sum(cfg_sum)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { int c; logic [NF-1:0] en; logic [FW-1:0] d; } strobe_t;
  strobe_t sq[$];
  int  ff_cyc = -1, rdy_cyc = -1, ready_cyc = -1;
  bit  in_gap = 1'b0;
  int  gap_idx = 0;
  logic p_ff = 1'b0, p_rdy = 1'b0, p_ready = 1'b0;

  always @(negedge clock) begin
    if (configs_en != '0) begin
      sq.push_back('{cyc, configs_en, configs_in});
      chk("ready_low_in_strobe", cfg_ready, 1'b0);
    end
    if (in_gap) begin
      chk("gap_idx", frame_idx, gap_idx);
      chk("gap_no_strobe", configs_en, 0);
    end
    if (ff_en && !p_ff && ff_cyc < 0) ff_cyc = cyc;
    if (rdy && !p_rdy && rdy_cyc < 0) rdy_cyc = cyc;
    if (cfg_ready && !p_ready && ready_cyc < 0) ready_cyc = cyc;
    p_ff = ff_en;
    p_rdy = rdy;
    p_ready = cfg_ready;
  end

  logic [FW-1:0] fd[5];
  int acc_c[5];

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Offer one frame; accepted when cfg_ready is seen high before an edge.
  task automatic send_frame(input logic [FW-1:0] d, input bit last, input int budget,
                            output bit acc, output int ac);
    acc = 1'b0;
    ac = -1;
    cfg_data = d;
    cfg_last = last;
    cfg_valid = 1'b1;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clock);
      if (cfg_ready) begin
        @(posedge clock);
        #1;
        acc = 1'b1;
        ac = cyc;
      end
    end
    cfg_valid = 1'b0;
    cfg_last = 1'b0;
    cfg_data = $urandom;
  endtask

  task automatic run_stream(input int n, input int last_at, input int gap_at,
                            input int gap_len, input bit rnd_gap, input bit sum_bad);
    int term, st_cyc, ac;
    bit acc, valid_final, exp_err;
    logic [15:0] exp_sum;
    term = n - 1;
    for (int i = 0; i < n; i++) begin
      if (i == last_at || i == NF - 1) begin
        term = i;
        break;
      end
    end
    exp_sum = '0;
    for (int i = 0; i <= term; i++) exp_sum ^= fd[i][31:16] ^ fd[i][15:0];
    valid_final = (term == NF - 1) && (last_at == term);
    exp_err = !valid_final || (CK && sum_bad);
    if (CK) cfg_sum_exp = sum_bad ? exp_sum ^ 16'($urandom_range(1, 65535)) : exp_sum;
    else    cfg_sum_exp = 16'($urandom);

    sq.delete();
    ff_cyc = -1;
    rdy_cyc = -1;
    ready_cyc = -1;
    start = 1'b1;
    idle(1);
    start = 1'b0;
    st_cyc = cyc;
    chk("busy_after_start", busy, 1'b1);
    chk("rdy_cleared", rdy, 1'b0);
    chk("ff_en_cleared", ff_en, 1'b0);
    chk("error_cleared", error, 1'b0);

    for (int i = 0; i <= term; i++) begin
      if (i == gap_at) begin
        idle(1);
        gap_idx = i;
        in_gap = 1'b1;
        idle(gap_len - 1);
        in_gap = 1'b0;
      end else if (rnd_gap) begin
        idle($urandom_range(0, 3));
      end
      send_frame(fd[i], (i == last_at), 60, acc, ac);
      chk("accept", acc, 1'b1);
      acc_c[i] = ac;
    end
    if (n > term + 1) begin
      send_frame(fd[term + 1], 1'b0, 10, acc, ac);
      chk("no_accept_after_end", acc, 1'b0);
    end

    for (int i = 0; i < 60 && busy; i++) idle(1);
    chk("finished", busy, 1'b0);
    idle(2);
    chk("error", error, exp_err);
    chk("ff_en", ff_en, !exp_err);
    chk("rdy", rdy, !exp_err);
    chk("ready_idle", cfg_ready, 1'b0);
    chk("en_idle", configs_en, 0);
    chk("cfg_sum", cfg_sum, CK ? exp_sum : 16'h0);
    chk("frame_idx_end", frame_idx, (term + 1) % NF);
    chk("pre_delay", ready_cyc - st_cyc, PRE);
    chk("n_strobes", sq.size(), term + 1);
    for (int i = 0; i < sq.size() && i <= term; i++) begin
      chk("strobe_en", sq[i].en, 1 << i);
      chk("strobe_data", sq[i].d, fd[i]);
      chk("strobe_cycle", sq[i].c, acc_c[i]);
    end
    if (!exp_err && sq.size() > 0) begin
      chk("settle_delay", ff_cyc - sq[sq.size() - 1].c, SETTLE + 1);
      chk("arm_delay", rdy_cyc - ff_cyc, ARM);
    end
  endtask

  task automatic set_nominal();
    fd[0] = 32'h11111111; fd[1] = 32'h22222222;
    fd[2] = 32'h33333333; fd[3] = 32'h44444444;
    fd[4] = 32'h55555555;
  endtask

  initial begin
    bit acc;
    int ac, la;
    #1;
    chk("rst_state_busy", busy, 1'b0);
    chk("rst_configs_en", configs_en, 0);
    chk("rst_configs_in", configs_in, 0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_ff_rdy_err", {ff_en, rdy, error}, 0);
    chk("rst_idx_sum", {frame_idx, cfg_sum}, 0);
    @(negedge clock);
    rst = 1'b0;
    idle(2);

    set_nominal();
    run_stream(4, 3, -1, 0, 1'b0, 1'b0);   // nominal back-to-back
    run_stream(4, 3, 2, 5, 1'b0, 1'b0);    // gap before the third frame
    run_stream(2, 1, -1, 0, 1'b0, 1'b0);   // short stream
    run_stream(5, -1, -1, 0, 1'b0, 1'b0);  // long stream

    // asynchronous reset during the WRITE of frame 2
    start = 1'b1;
    idle(1);
    start = 1'b0;
    send_frame(fd[0], 1'b0, 60, acc, ac);
    send_frame(fd[1], 1'b0, 60, acc, ac);
    chk("pre_reset_strobe", configs_en, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_en", configs_en, 0);
    chk("async_rst_in", configs_in, 0);
    chk("async_rst_busy_idx", {busy, frame_idx}, 0);
    @(negedge clock);
    rst = 1'b0;
    idle(1);
    run_stream(4, 3, -1, 0, 1'b0, 1'b0);

    fd[0] = 32'h00010002; fd[1] = 32'h00030004; fd[2] = '0; fd[3] = '0;
    run_stream(4, 3, -1, 0, 1'b0, 1'b0);
    run_stream(4, 3, -1, 0, 1'b0, 1'b1);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 5; i++) fd[i] = $urandom;
      la = $urandom_range(0, 4);
      if (la == 4) run_stream(5, -1, -1, 0, 1'b1, 1'($urandom_range(0, 1)));
      else         run_stream(la + 1, la, -1, 0, 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
